mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory-access stage plus MEM/WB pipeline register. Sits directly downstream of the EX/MEM register.
- Performs loads and stores through a req/ack data-memory port and stalls the upstream pipeline while an access is outstanding.
- Selects the write-back value (memory data or ALU result) and registers it, with the destination register and RegWrite, for the WB stage.
- Flags misaligned accesses and memory timeouts on a sticky error output.

Parameters:
- LENGTH, 32, datapath width (matches `LENGTH).
- TIMEOUT_CYCLES, 16, number of ACCESS cycles without dmem_ack before the access is abandoned; must be >= 1.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- Memwrite_in  in  1  store request from EX/MEM.
- RegWrite_in  in  1  register write enable from EX/MEM.
- Write_reg_mux_in  in  1  1 = write back memory data (load), 0 = write back ALU result.
- ALU_out_in  in  LENGTH  ALU result; doubles as memory byte address.
- Write_memory_Data_in  in  LENGTH  store data.
- Write_Reg_Address_in  in  5  destination register.
- dmem_rdata  in  LENGTH  read data, valid when dmem_ack=1.
- dmem_ack  in  1  one-cycle access-complete pulse.
- err_clr  in  1  clears mem_err.
- dmem_req  out  1  access request (registered).
- dmem_we  out  1  1 = write (registered).
- dmem_addr  out  LENGTH  word-aligned address (registered).
- dmem_wdata  out  LENGTH  store data (registered).
- stall  out  1  upstream must hold EX/MEM contents this cycle (combinational).
- RegWrite_out  out  1  WB write enable.
- Write_Reg_Address_out  out  5  WB destination register.
- Write_back_Data_out  out  LENGTH  WB data.
- mem_err  out  1  sticky error flag.

Behaviour:
- Operation classes:
  - mem_op = Memwrite_in | (RegWrite_in & Write_reg_mux_in).
  - misaligned = mem_op & (ALU_out_in[1:0] != 0).
  - Any other input is a non-memory op, including a bubble (all enables 0).
- Reset (async, immediate): state=IDLE; counter=0; dmem_req=0, dmem_we=0, dmem_addr=0, dmem_wdata=0; RegWrite_out=0, Write_Reg_Address_out=0, Write_back_Data_out=0; mem_err=0.
  - A reset mid-access drops dmem_req at once. A late dmem_ack is then ignored.
- FSM states: IDLE, ACCESS.
- IDLE, non-memory op:
  - stall=0.
  - Next edge: RegWrite_out<=RegWrite_in, Write_Reg_Address_out<=Write_Reg_Address_in, Write_back_Data_out<=ALU_out_in.
  - Latency 1 cycle.
- IDLE, misaligned:
  - No request issued; stall=0; mem_err<=1.
  - MEM/WB loads a bubble: RegWrite_out<=0, data<=0.
  - A misaligned store is dropped.
- IDLE, aligned mem_op:
  - stall=1.
  - Next edge: dmem_req<=1, dmem_we<=Memwrite_in, dmem_addr<=ALU_out_in, dmem_wdata<=Write_memory_Data_in; counter<=0; go to ACCESS.
  - MEM/WB loads a bubble.
- ACCESS:
  - Inputs are held stable by upstream. dmem_req stays 1.
  - stall = ~dmem_ack & (counter != TIMEOUT_CYCLES-1).
  - dmem_ack=1:
    - stall=0.
    - Next edge: dmem_req<=0; state<=IDLE.
    - Load: RegWrite_out<=RegWrite_in, Write_back_Data_out<=dmem_rdata.
    - Store: RegWrite_out<=RegWrite_in, data<=ALU_out_in.
    - Minimum mem_op latency is 2 cycles (ack in the first ACCESS cycle).
  - No ack and counter==TIMEOUT_CYCLES-1 (timeout):
    - stall=0; dmem_req<=0; state<=IDLE; mem_err<=1.
    - MEM/WB loads a bubble.
  - Otherwise: counter<=counter+1; MEM/WB loads a bubble so WB never repeats a write.
- Simultaneous ack and timeout: ack wins, mem_err unchanged.
- dmem_ack while in IDLE: ignored.
- mem_err: set on misalignment or timeout, cleared by err_clr. If set and clear occur in the same cycle, set wins.
- dmem_* outputs change only on clock edges or at reset.

Test Plan:
- Non-memory op: ALU_out_in=0x0000_0010, RegWrite_in=1, reg=5. Expect after 1 edge: RegWrite_out=1, addr=5, data=0x10, stall=0 throughout.
- Load with ack in the first ACCESS cycle: addr 0x100, dmem_rdata=0xDEAD_BEEF. Expect:
  - stall=1 for the issue cycle; dmem_req=1, we=0, dmem_addr=0x100.
  - Next edge: Write_back_Data_out=0xDEAD_BEEF, RegWrite_out=1.
  - Exactly one WB write.
- Store with ack after 3 wait cycles: addr 0x20, data 0x1234_5678. Expect:
  - dmem_we=1, dmem_wdata=0x1234_5678.
  - stall held for 4 cycles then drops.
  - RegWrite_out=0 on every intermediate cycle.
- Timeout (TIMEOUT_CYCLES=4, ack never asserted): expect dmem_req high for 4 cycles, then mem_err=1, stall=0, RegWrite_out=0. Then err_clr=1 clears mem_err.
- Misaligned load at addr 0x102: expect no dmem_req, stall=0, mem_err=1 next edge, RegWrite_out=0.
- Reset asserted mid-ACCESS: expect dmem_req=0 immediately (before the next edge) and all outputs at 0. A load issued after reset completes normally.

Source files
------------

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: memory-access stage plus MEM/WB pipeline register.
//
// Issues loads/stores on a registered req/ack data-memory port, stalls the
// upstream pipeline while an access is outstanding, selects the write-back
// value (memory read data or ALU result) and registers it together with the
// destination register and RegWrite for the WB stage. Misaligned accesses and
// memory timeouts raise the sticky mem_err flag, cleared by err_clr.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   Memwrite_in              store request from EX/MEM
//   RegWrite_in              register write enable from EX/MEM
//   Write_reg_mux_in         1 = write back memory data, 0 = ALU result
//   ALU_out_in               ALU result / memory byte address
//   Write_memory_Data_in     store data
//   Write_Reg_Address_in     destination register
//   dmem_rdata, dmem_ack     memory read data and one-cycle completion pulse
//   err_clr                  clears mem_err
//   dmem_req/we/addr/wdata   registered memory request
//   stall                    upstream must hold EX/MEM this cycle (comb.)
//   RegWrite_out, Write_Reg_Address_out, Write_back_Data_out   WB register
//   mem_err                  sticky error flag
module mem_wb_stage #(
  parameter int LENGTH         = 32,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Memwrite_in,
  input  logic              RegWrite_in,
  input  logic              Write_reg_mux_in,
  input  logic [LENGTH-1:0] ALU_out_in,
  input  logic [LENGTH-1:0] Write_memory_Data_in,
  input  logic [4:0]        Write_Reg_Address_in,
  input  logic [LENGTH-1:0] dmem_rdata,
  input  logic              dmem_ack,
  input  logic              err_clr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [LENGTH-1:0] dmem_addr,
  output logic [LENGTH-1:0] dmem_wdata,
  output logic              stall,
  output logic              RegWrite_out,
  output logic [4:0]        Write_Reg_Address_out,
  output logic [LENGTH-1:0] Write_back_Data_out,
  output logic              mem_err
);

  typedef enum logic {
    IDLE,
    ACCESS
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_d, we_d;
  logic [LENGTH-1:0] addr_d, wdata_d;
  logic              rw_d;
  logic [4:0]        wra_d;
  logic [LENGTH-1:0] wbd_d;
  logic              err_d;
  logic              set_err;

  logic mem_op, misaligned, is_load;

  assign mem_op     = Memwrite_in | (RegWrite_in & Write_reg_mux_in);
  assign misaligned = mem_op & (ALU_out_in[1:0] != 2'b00);
  assign is_load    = RegWrite_in & Write_reg_mux_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q               <= IDLE;
      cnt_q                 <= '0;
      dmem_req              <= 1'b0;
      dmem_we               <= 1'b0;
      dmem_addr             <= '0;
      dmem_wdata            <= '0;
      RegWrite_out          <= 1'b0;
      Write_Reg_Address_out <= '0;
      Write_back_Data_out   <= '0;
      mem_err               <= 1'b0;
    end else begin
      state_q               <= state_d;
      cnt_q                 <= cnt_d;
      dmem_req              <= req_d;
      dmem_we               <= we_d;
      dmem_addr             <= addr_d;
      dmem_wdata            <= wdata_d;
      RegWrite_out          <= rw_d;
      Write_Reg_Address_out <= wra_d;
      Write_back_Data_out   <= wbd_d;
      mem_err               <= err_d;
    end
  end

  // Every path that does not complete an instruction loads a bubble into
  // MEM/WB, so wait cycles never repeat a register write.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = dmem_req;
    we_d    = dmem_we;
    addr_d  = dmem_addr;
    wdata_d = dmem_wdata;
    rw_d    = 1'b0;
    wra_d   = '0;
    wbd_d   = '0;
    stall   = 1'b0;
    set_err = 1'b0;

    case (state_q)
      IDLE: begin
        if (misaligned) begin
          set_err = 1'b1;
        end else if (mem_op) begin
          stall   = 1'b1;
          state_d = ACCESS;
          cnt_d   = '0;
          req_d   = 1'b1;
          we_d    = Memwrite_in;
          addr_d  = {ALU_out_in[LENGTH-1:2], 2'b00};
          wdata_d = Write_memory_Data_in;
        end else begin
          rw_d  = RegWrite_in;
          wra_d = Write_Reg_Address_in;
          wbd_d = ALU_out_in;
        end
      end
      ACCESS: begin
        // ack is checked first so it beats a coincident timeout.
        if (dmem_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          rw_d    = RegWrite_in;
          wra_d   = Write_Reg_Address_in;
          wbd_d   = is_load ? dmem_rdata : ALU_out_in;
        end else if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
          req_d   = 1'b0;
          set_err = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Set has priority over a same-cycle clear.
    err_d = set_err ? 1'b1 : (err_clr ? 1'b0 : mem_err);
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        Memwrite_in = 1'b0;
  logic        RegWrite_in = 1'b0;
  logic        Write_reg_mux_in = 1'b0;
  logic [31:0] ALU_out_in = '0;
  logic [31:0] Write_memory_Data_in = '0;
  logic [4:0]  Write_Reg_Address_in = '0;
  logic [31:0] dmem_rdata = '0;
  logic        dmem_ack = 1'b0;
  logic        err_clr = 1'b0;
  logic        dmem_req, dmem_we, stall, RegWrite_out, mem_err;
  logic [31:0] dmem_addr, dmem_wdata, Write_back_Data_out;
  logic [4:0]  Write_Reg_Address_out;

  int errors = 0;
  int checks = 0;

  mem_wb_stage #(.LENGTH(32), .TIMEOUT_CYCLES(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst),
    .Memwrite_in(Memwrite_in), .RegWrite_in(RegWrite_in),
    .Write_reg_mux_in(Write_reg_mux_in), .ALU_out_in(ALU_out_in),
    .Write_memory_Data_in(Write_memory_Data_in),
    .Write_Reg_Address_in(Write_Reg_Address_in),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .err_clr(err_clr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .stall(stall), .RegWrite_out(RegWrite_out),
    .Write_Reg_Address_out(Write_Reg_Address_out),
    .Write_back_Data_out(Write_back_Data_out), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mw, input logic rw, input logic mux,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [4:0] ra);
    Memwrite_in          = mw;
    RegWrite_in          = rw;
    Write_reg_mux_in     = mux;
    ALU_out_in           = alu;
    Write_memory_Data_in = wd;
    Write_Reg_Address_in = ra;
  endtask

  initial begin
    // Reset values
    #2;
    chk1("rst_req", dmem_req, 1'b0);
    chk32("rst_addr", dmem_addr, 32'h0);
    chk1("rst_rw", RegWrite_out, 1'b0);
    chk32("rst_wbd", Write_back_Data_out, 32'h0);
    chk1("rst_err", mem_err, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Non-memory op
    drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 5'd5);
    #1 chk1("alu_stall", stall, 1'b0);
    step();
    chk1("alu_rw", RegWrite_out, 1'b1);
    chk32("alu_ra", 32'(Write_Reg_Address_out), 32'd5);
    chk32("alu_wbd", Write_back_Data_out, 32'h10);
    chk1("alu_req", dmem_req, 1'b0);

    // Load, ack in first ACCESS cycle
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7);
    #1 chk1("ld_issue_stall", stall, 1'b1);
    step();
    chk1("ld_req", dmem_req, 1'b1);
    chk1("ld_we", dmem_we, 1'b0);
    chk32("ld_addr", dmem_addr, 32'h100);
    chk1("ld_issue_rw", RegWrite_out, 1'b0);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hDEADBEEF;
    #1 chk1("ld_ack_stall", stall, 1'b0);
    step();
    chk32("ld_wbd", Write_back_Data_out, 32'hDEADBEEF);
    chk1("ld_rw", RegWrite_out, 1'b1);
    chk32("ld_ra", 32'(Write_Reg_Address_out), 32'd7);
    chk1("ld_req_drop", dmem_req, 1'b0);

    // Bubble with a stray ack while IDLE: ignored
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE0000;
    #1 chk1("idle_ack_stall", stall, 1'b0);
    step();
    chk1("ld_single_wb", RegWrite_out, 1'b0);
    chk1("idle_ack_req", dmem_req, 1'b0);
    chk32("idle_ack_wbd", Write_back_Data_out, 32'h0);

    // Store, ack after 3 wait cycles (ack coincides with last timeout cycle)
    @(negedge clk);
    dmem_ack = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 32'h20, 32'h12345678, 5'd0);
    #1 chk1("st_issue_stall", stall, 1'b1);
    step();
    chk1("st_req", dmem_req, 1'b1);
    chk1("st_we", dmem_we, 1'b1);
    chk32("st_addr", dmem_addr, 32'h20);
    chk32("st_wdata", dmem_wdata, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 chk1("st_wait_stall", stall, 1'b1);
      step();
      chk1("st_wait_rw", RegWrite_out, 1'b0);
      chk1("st_wait_req", dmem_req, 1'b1);
    end
    @(negedge clk);
    dmem_ack = 1'b1;
    #1 chk1("st_ack_stall", stall, 1'b0);
    step();
    chk1("st_done_req", dmem_req, 1'b0);
    chk1("st_done_rw", RegWrite_out, 1'b0);
    chk32("st_done_wbd", Write_back_Data_out, 32'h20);
    chk1("st_ack_beats_to", mem_err, 1'b0);

    // Timeout: ack never arrives
    @(negedge clk);
    dmem_ack = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h40, 32'h0, 5'd3);
    step();
    chk1("to_req", dmem_req, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1 chk1("to_stall", stall, (i < 3));
      step();
      chk1("to_req_cyc", dmem_req, (i < 3));
      chk1("to_err_cyc", mem_err, (i == 3));
      chk1("to_rw_cyc", RegWrite_out, 1'b0);
    end
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    err_clr = 1'b1;
    step();
    chk1("to_err_clr", mem_err, 1'b0);

    // Misaligned load
    @(negedge clk);
    err_clr = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd4);
    #1 chk1("mis_stall", stall, 1'b0);
    step();
    chk1("mis_req", dmem_req, 1'b0);
    chk1("mis_err", mem_err, 1'b1);
    chk1("mis_rw", RegWrite_out, 1'b0);
    chk32("mis_wbd", Write_back_Data_out, 32'h0);
    // Set and clear in the same cycle: set wins
    @(negedge clk);
    err_clr = 1'b1;
    step();
    chk1("mis_set_wins", mem_err, 1'b1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk1("mis_clr", mem_err, 1'b0);

    // Reset mid-ACCESS
    @(negedge clk);
    err_clr = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 32'h200, 32'h0, 5'd9);
    step();
    chk1("rm_req_before", dmem_req, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk1("rm_req", dmem_req, 1'b0);
    chk32("rm_addr", dmem_addr, 32'h0);
    chk1("rm_rw", RegWrite_out, 1'b0);
    chk32("rm_wbd", Write_back_Data_out, 32'h0);
    chk1("rm_err", mem_err, 1'b0);
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    step();
    @(negedge clk);
    rst = 1'b0;
    dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();
    chk1("rm_late_ack_req", dmem_req, 1'b0);
    chk1("rm_late_ack_rw", RegWrite_out, 1'b0);

    // Load after reset completes normally
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 32'h300, 32'h0, 5'd11);
    step();
    chk32("pr_addr", dmem_addr, 32'h300);
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'h0BADF00D;
    step();
    chk32("pr_wbd", Write_back_Data_out, 32'h0BADF00D);
    chk1("pr_rw", RegWrite_out, 1'b1);
    chk32("pr_ra", 32'(Write_Reg_Address_out), 32'd11);
    @(negedge clk);
    dmem_ack = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
